ntt_butterfly_unit: RTL and testbench
=====================================

# ntt_butterfly_unit

Pipelined modular butterfly for the Kyber NTT/INTT datapath (q = 3329). It sits directly downstream of the NTT controller: it takes two coefficients and a twiddle per cycle and returns the transformed pair a fixed 3 cycles later. The controller writes that pair back into the ping-pong BRAM banks. The unit computes Cooley-Tukey butterflies for forward NTT and Gentleman-Sande butterflies for inverse NTT, selected per transaction.

## Interface
- DATA_WIDTH, 12: coefficient and twiddle width.
- Q, 3329: modulus. Barrett constants are derived for Q = 3329, DATA_WIDTH = 12 only; other values are a elaboration-time error.
- LATENCY, 3: pipeline depth. Fixed; any other value is an elaboration-time error.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  transaction strobe; one butterfly per cycle when high.
- butterfly_in1  in  DATA_WIDTH  coefficient a, range [0, Q-1].
- butterfly_in2  in  DATA_WIDTH  coefficient b, range [0, Q-1].
- butterfly_twiddle  in  DATA_WIDTH  twiddle w, range [0, Q-1].
- butterfly_inverse  in  1  0 = NTT (CT), 1 = INTT (GS); sampled per transaction.
- valid_out  out  1  result strobe.
- butterfly_u  out  DATA_WIDTH  result u, range [0, Q-1].
- butterfly_v  out  DATA_WIDTH  result v, range [0, Q-1].

## Operation
- NTT: t = (w*b) mod Q; u = (a+t) mod Q; v = (a-t) mod Q.
- INTT: u = (a+b) mod Q; v = ((a-b)*w) mod Q.
- Pipeline, each stage carries a valid bit and its inverse flag:
  - S1 registers a, b, w, inverse. For INTT it also registers the reduced sum and difference. The difference is computed as a-b+Q, then has Q subtracted if the result is at least Q.
  - S2 forms the 24-bit product: w*b for NTT, w*(a-b) for INTT. It also forms the Barrett quotient estimate t_q = (p*5039) >> 24.
  - S3 computes r = p - t_q*Q, applies at most one conditional subtraction of Q, then does the final add/sub (NTT) or passes through (INTT). The result is registered to the outputs.
- Every arithmetic result is fully reduced to [0, Q-1]. The Barrett stage is exact for every product p < Q², because a single correction suffices for p < 2^24.
- Intermediate widths: sums are 13 bits; the product is 24 bits; the Barrett multiply is 37 bits, truncated after the shift.
- No backpressure. Throughput is one transaction per cycle. The valid_in pattern is reproduced on valid_out, delayed by exactly 3 cycles, with no merging or dropping.
- Data registers load only when the corresponding stage valid is high. butterfly_u and butterfly_v hold their last value while valid_out is low.
- Out-of-range inputs (≥ Q) produce undefined u and v; valid timing is unaffected.
- The inverse flag travels with its data. Mixing NTT and INTT on consecutive cycles is legal and each transaction uses its own mode.

## Timing
- Reset: all stage valid bits, valid_out, butterfly_u and butterfly_v are cleared to 0 asynchronously.
- Reset mid-operation: in-flight transactions are discarded. valid_out is low from reset assertion until 3 edges after the first valid_in following deassertion.
- Latency: valid_in high at rising edge E0 gives valid_out high, with the corresponding u and v, in the cycle following edge E3.
- Outputs are registered: no combinational path from any input to any output.
- Occupancy: valid_out is low at most 3 cycles after the last valid_in. The controller's flush relies on this.

## Configuration
- INTT_HALVE_EN defined: in INTT mode, S3 multiplies both u and v by 2⁻¹ mod Q before registering.
  - x even → x/2; x odd → (x+Q)/2.
  - Over the 8 INTT layers this folds the n⁻¹ scaling into the butterflies.
  - NTT mode is unchanged; latency stays 3.
- INTT_HALVE_EN undefined: INTT outputs are unscaled; an external stage applies n⁻¹.

## Test plan
- Reset, then NTT with a=5, b=7, w=17 → 3 cycles later u=124, v=3215, valid_out high for exactly 1 cycle.
- INTT with a=5, b=7, w=17 → u=12, v=3295 without INTT_HALVE_EN; u=6, v=3312 with it.
- Boundary NTT with a=b=w=3328 → u=0, v=3327. NTT with a=0, b=0, w=0 → u=0, v=0.
- 256 back-to-back random transactions with random per-cycle mode and random valid gaps → every result matches the software model, valid_out pattern equals valid_in delayed by 3, no lost or duplicate strobes.
- Issue 3 transactions, assert rst for 1 cycle with 2 still in flight → valid_out, u and v are 0 immediately. No stale results appear afterwards. The next transaction completes normally after 3 cycles.
- Exhaustive Barrett check: sweep all b in [0, 3328] with w=3328, NTT, a=0 → v equals (-(3328*b)) mod 3329 for every b.

Source files
------------

// File: rtl/ntt_butterfly_unit.sv
// Pipelined Kyber butterfly (q = 3329): Cooley-Tukey for NTT, Gentleman-Sande for INTT.
// Optional macro INTT_HALVE_EN: scale both INTT outputs by 2^-1 mod q.
module ntt_butterfly_unit #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] butterfly_in1,
  input  logic [DATA_WIDTH-1:0] butterfly_in2,
  input  logic [DATA_WIDTH-1:0] butterfly_twiddle,
  input  logic                  butterfly_inverse,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] butterfly_u,
  output logic [DATA_WIDTH-1:0] butterfly_v
);

  localparam logic [12:0] QW      = 13'(Q);
  localparam logic [36:0] BARRETT = 37'd5039;

  generate
    if (Q != 3329 || DATA_WIDTH != 12 || LATENCY != 3) begin : g_bad_cfg
      $error("ntt_butterfly_unit supports only Q=3329, DATA_WIDTH=12, LATENCY=3");
    end
  endgenerate

  // Stage 1: operands and, for INTT, the reduced sum and difference
  logic        v1_q, v1_d, inv1_q, inv1_d;
  logic [11:0] a1_q, a1_d, b1_q, b1_d, w1_q, w1_d, sum1_q, sum1_d, dif1_q, dif1_d;
  // Stage 2a: product plus the value that bypasses the multiplier
  logic        v2_q, v2_d, inv2_q, inv2_d;
  logic [11:0] x2_q, x2_d;
  logic [23:0] p2_q, p2_d;
  // Stage 2b: product plus Barrett quotient estimate
  logic        v3_q, v3_d, inv3_q, inv3_d;
  logic [11:0] x3_q, x3_d, tq3_q, tq3_d;
  logic [23:0] p3_q, p3_d;
  // Output registers
  logic        vo_q, vo_d;
  logic [11:0] u_q, u_d, vv_q, vv_d;

  logic [12:0] sum_raw, dif_raw, r_raw, t_red, s_raw, d_raw, u_res, v_res;
  logic [11:0] mul_op;

`ifdef INTT_HALVE_EN
  function automatic logic [12:0] halve(input logic [12:0] x);
    logic [13:0] ext;
    ext = x[0] ? (14'(x) + 14'(QW)) : 14'(x);
    return ext[13:1];
  endfunction
`endif

  always_comb begin
    sum_raw = 13'(butterfly_in1) + 13'(butterfly_in2);
    dif_raw = 13'(butterfly_in1) + QW - 13'(butterfly_in2);
    if (sum_raw >= QW) sum_raw = sum_raw - QW;
    if (dif_raw >= QW) dif_raw = dif_raw - QW;

    v1_d   = valid_in;
    inv1_d = inv1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    w1_d   = w1_q;
    sum1_d = sum1_q;
    dif1_d = dif1_q;
    if (valid_in) begin
      inv1_d = butterfly_inverse;
      a1_d   = butterfly_in1;
      b1_d   = butterfly_in2;
      w1_d   = butterfly_twiddle;
      if (butterfly_inverse) begin
        sum1_d = sum_raw[11:0];
        dif1_d = dif_raw[11:0];
      end
    end
  end

  always_comb begin
    mul_op = inv1_q ? dif1_q : b1_q;
    v2_d   = v1_q;
    inv2_d = inv2_q;
    x2_d   = x2_q;
    p2_d   = p2_q;
    if (v1_q) begin
      inv2_d = inv1_q;
      x2_d   = inv1_q ? sum1_q : a1_q;
      p2_d   = 24'(w1_q) * 24'(mul_op);
    end
  end

  // Quotient estimate floor(p*5039/2^24) undershoots floor(p/q) by at most one
  always_comb begin
    v3_d   = v2_q;
    inv3_d = inv3_q;
    x3_d   = x3_q;
    p3_d   = p3_q;
    tq3_d  = tq3_q;
    if (v2_q) begin
      inv3_d = inv2_q;
      x3_d   = x2_q;
      p3_d   = p2_q;
      tq3_d  = 12'((37'(p2_q) * BARRETT) >> 24);
    end
  end

  // Remainder is below 2q, so 13 bits of the difference are exact
  always_comb begin
    r_raw = p3_q[12:0] - 13'(24'(tq3_q) * 24'(Q));
    t_red = (r_raw >= QW) ? (r_raw - QW) : r_raw;
    s_raw = 13'(x3_q) + t_red;
    d_raw = 13'(x3_q) + QW - t_red;
    if (s_raw >= QW) s_raw = s_raw - QW;
    if (d_raw >= QW) d_raw = d_raw - QW;
    if (inv3_q) begin
`ifdef INTT_HALVE_EN
      u_res = halve(13'(x3_q));
      v_res = halve(t_red);
`else
      u_res = 13'(x3_q);
      v_res = t_red;
`endif
    end else begin
      u_res = s_raw;
      v_res = d_raw;
    end
    vo_d = v3_q;
    u_d  = v3_q ? u_res[11:0] : u_q;
    vv_d = v3_q ? v_res[11:0] : vv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      vo_q <= 1'b0;
      u_q  <= '0;
      vv_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      vo_q <= vo_d;
      u_q  <= u_d;
      vv_q <= vv_d;
    end
  end

  // Data-only registers need no reset; they are qualified by the stage valids
  always_ff @(posedge clk) begin
    inv1_q <= inv1_d;
    a1_q   <= a1_d;
    b1_q   <= b1_d;
    w1_q   <= w1_d;
    sum1_q <= sum1_d;
    dif1_q <= dif1_d;
    inv2_q <= inv2_d;
    x2_q   <= x2_d;
    p2_q   <= p2_d;
    inv3_q <= inv3_d;
    x3_q   <= x3_d;
    p3_q   <= p3_d;
    tq3_q  <= tq3_d;
  end

  assign valid_out   = vo_q;
  assign butterfly_u = u_q;
  assign butterfly_v = vv_q;

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Self-checking bench for ntt_butterfly_unit against an arithmetic model of the butterfly.
// Honours INTT_HALVE_EN the same way the design does.
module tb_ntt_butterfly_unit;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [11:0] butterfly_in1 = '0, butterfly_in2 = '0, butterfly_twiddle = '0;
  logic        butterfly_inverse = 1'b0;
  logic        valid_out;
  logic [11:0] butterfly_u, butterfly_v;

  int tests = 0;
  int fails = 0;
  int last_u = 0, last_v = 0;

  typedef struct {
    bit vld;
    int u;
    int v;
  } exp_t;
  exp_t exp_q[$];

  ntt_butterfly_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .butterfly_in1(butterfly_in1), .butterfly_in2(butterfly_in2),
    .butterfly_twiddle(butterfly_twiddle), .butterfly_inverse(butterfly_inverse),
    .valid_out(valid_out), .butterfly_u(butterfly_u), .butterfly_v(butterfly_v)
  );

  always #5 clk = ~clk;

  function automatic int half(input int x);
`ifdef INTT_HALVE_EN
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
`else
    return x;
`endif
  endfunction

  function automatic void model(input int a, b, w, input bit inv, output int u, v);
    int t;
    if (!inv) begin
      t = (w * b) % Q;
      u = (a + t) % Q;
      v = (a - t + Q) % Q;
    end else begin
      u = half((a + b) % Q);
      v = half((((a - b + Q) % Q) * w) % Q);
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Output is empty for the next three cycles after any reset
  task automatic clear_model();
    exp_t e;
    e.vld = 1'b0; e.u = 0; e.v = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(e);
    last_u = 0;
    last_v = 0;
  endtask

  task automatic step(input bit vld, input int a, input int b, input int w, input bit inv);
    exp_t e;
    int eu, ev;
    eu = 0; ev = 0;
    valid_in          = vld;
    butterfly_in1     = 12'(a);
    butterfly_in2     = 12'(b);
    butterfly_twiddle = 12'(w);
    butterfly_inverse = inv;
    if (vld) model(a, b, w, inv, eu, ev);
    e.vld = vld; e.u = eu; e.v = ev;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.vld) begin
      last_u = e.u;
      last_v = e.v;
    end
    chk("valid_out", int'(valid_out), int'(e.vld));
    chk("u", int'(butterfly_u), last_u);
    chk("v", int'(butterfly_v), last_v);
  endtask

  task automatic idle();
    step(1'b0, int'($urandom_range(4095)), int'($urandom_range(4095)),
         int'($urandom_range(4095)), 1'($urandom_range(1)));
  endtask

  initial begin
    int issued, u_e, v_e;
    #1;
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_u", int'(butterfly_u), 0);
    chk("reset_v", int'(butterfly_v), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();

    // Directed cases from the block's worked examples
    step(1'b1, 5, 7, 17, 1'b0);
    repeat (4) idle();
    model(5, 7, 17, 1'b0, u_e, v_e);
    chk("ntt_example_u", u_e, 124);
    chk("ntt_example_v", v_e, 3215);
    step(1'b1, 5, 7, 17, 1'b1);
    repeat (4) idle();
    step(1'b1, 3328, 3328, 3328, 1'b0);
    repeat (4) idle();
    chk("boundary_u", last_u, 0);
    chk("boundary_v", last_v, 3327);
    step(1'b1, 0, 0, 0, 1'b0);
    repeat (4) idle();

    // Random traffic with mixed modes and gaps
    issued = 0;
    while (issued < 256) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
             int'($urandom_range(Q - 1)), 1'($urandom_range(1)));
        issued++;
      end else begin
        idle();
      end
    end
    repeat (4) idle();

    // Reset with two transactions still in flight
    step(1'b1, 100, 200, 300, 1'b0);
    step(1'b1, 1000, 20, 3000, 1'b1);
    step(1'b1, 7, 3000, 42, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    chk("midreset_valid_out", int'(valid_out), 0);
    chk("midreset_u", int'(butterfly_u), 0);
    chk("midreset_v", int'(butterfly_v), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    repeat (5) idle();
    step(1'b1, 1234, 2345, 3111, 1'b0);
    repeat (4) idle();

    // Barrett sweep: every b with the largest twiddle
    for (int b = 0; b < Q; b++) begin
      step(1'b1, 0, b, 3328, 1'b0);
      if (b >= 3) chk("sweep_v_formula", last_v, (Q - ((3328 * (b - 3)) % Q)) % Q);
    end
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
